// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Receive front end for an 8N1 serial line at a fixed bit period. It
// synchronises the asynchronous rx pin, recovers frames with a four-state FSM,
// and buffers completed bytes in a small show-ahead FIFO. The CPU bus pops
// bytes one per cycle and polls two sticky error flags.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (>= 4)
//   FIFO_DEPTH   : receive buffer entries (power of two, >= 2)
//
// Ports:
//   clk       in  1  system clock, rising edge
//   reset     in  1  asynchronous active-high reset
//   rx        in  1  serial line, idle high, asynchronous to clk
//   rd_en     in  1  pop the FIFO head (ignored when empty)
//   clr_err   in  1  clear frame_err and overrun
//   rd_data   out 8  FIFO head byte (show-ahead, don't-care when empty)
//   rx_valid  out 1  FIFO not empty
//   level     out    number of bytes held (0..FIFO_DEPTH)
//   frame_err out 1  sticky: a stop bit was sampled low
//   overrun   out 1  sticky: a byte completed while the FIFO was full
//
// Handshake: rd_en is a plain request sampled on the rising edge; a pop
// happens only when rx_valid is high, and the next head appears on
// rd_data/level in the following cycle. There is no back-pressure on the
// serial side: a byte that finds the FIFO full is dropped and flagged.
//
// The receiver state is held in state_q (type state_t) so checkers can bind
// to it directly.
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [7:0]                    rd_data,
   output logic                          rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          frame_err,
   output logic                          overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   // Last counter value of the half-bit wait and of a full bit period.
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Synchroniser and falling-edge detect
   // ---------------------------------------------------------------------------
   logic rx_meta_q;
   logic rx_sync_q;
   logic rx_prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // Only a 1->0 transition starts a frame; a line stuck low never retriggers.
   logic fall_edge;
   assign fall_edge = rx_prev_q & ~rx_sync_q;

   // ---------------------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------------------
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          push;
   logic          frame_set;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      bit_d     = bit_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_set = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall_edge) begin
               bit_d   = '0;
               state_d = START;
            end
         end

         // Re-check the line half a bit in; a high line means the edge was
         // a glitch and is dropped silently.
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rx_sync_q ? IDLE : DATA;
            end
         end

         // From here on every sample lands mid-bit, one period apart.
         DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end

         // Leaving for IDLE right after the stop sample leaves half a bit of
         // margin to catch a back-to-back start edge.
         STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_sync_q) begin
                  push = 1'b1;
               end else begin
                  frame_set = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Receive FIFO
   // ---------------------------------------------------------------------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;

   logic fifo_full;
   logic fifo_empty;
   logic wr_ok;
   logic rd_ok;
   logic ovr_set;

   assign fifo_full  = (level_q == DEPTH_L);
   assign fifo_empty = (level_q == '0);
   assign rd_ok      = rd_en & ~fifo_empty;
   // A full FIFO is never empty, so a same-cycle pop always frees the slot.
   assign wr_ok      = push & (~fifo_full | rd_en);
   assign ovr_set    = push & fifo_full & ~rd_en;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({wr_ok, rd_ok})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // A new error in the same cycle as clr_err stays set.
   always_comb begin
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      if (clr_err) begin
         frame_err_d = 1'b0;
         overrun_d   = 1'b0;
      end
      if (frame_set) begin
         frame_err_d = 1'b1;
      end
      if (ovr_set) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Storage needs no reset: level_q gates every read of it.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   assign rd_data   = mem_q[rd_ptr_q];
   assign rx_valid  = ~fifo_empty;
   assign level     = level_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Bench for uart_rx with CLKS_PER_BIT=8, FIFO_DEPTH=4. Frames are driven on
// the pin by a bit-level driver; every byte the receiver should keep is
// pushed to exp_q when its frame is launched and compared when it is popped.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int C = 8;
   localparam int D = 4;

   logic       clk;
   logic       reset;
   logic       rx;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rd_data;
   logic       rx_valid;
   logic [2:0] level;
   logic       frame_err;
   logic       overrun;

   uart_rx #(
      .CLKS_PER_BIT (C),
      .FIFO_DEPTH   (D)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rd_en     (rd_en),
      .clr_err   (clr_err),
      .rd_data   (rd_data),
      .rx_valid  (rx_valid),
      .level     (level),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [7:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Drivers
   // ---------------------------------------------------------------------------
   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One 8N1 frame on the pin; the byte is expected in the FIFO if accept.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic accept);
      if (accept) exp_q.push_back(b);
      rx = 1'b0;
      repeat (C) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (C) tick();
      end
      rx = stop;
      repeat (C) tick();
      rx = 1'b1;
   endtask

   // Compare the head against the scoreboard and pop it.
   task automatic pop_check(input string name);
      rd_en = 1'b1;
      @(negedge clk);
      check({name, "_valid"}, {31'd0, rx_valid}, 32'd1);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: got %0h expected nothing queued", name, rd_data);
      end else begin
         check({name, "_data"}, {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
      end
      tick();
      rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   task automatic check_status(input string name, input logic valid, input logic [2:0] lvl,
                               input logic ferr, input logic ovr);
      @(negedge clk);
      check({name, "_rx_valid"},  {31'd0, rx_valid},  {31'd0, valid});
      check({name, "_level"},     {29'd0, level},     {29'd0, lvl});
      check({name, "_frame_err"}, {31'd0, frame_err}, {31'd0, ferr});
      check({name, "_overrun"},   {31'd0, overrun},   {31'd0, ovr});
   endtask

   // ---------------------------------------------------------------------------
   // Vector table: single frames, each checked in isolation
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic [2:0] exp_level;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[6];

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   int first_valid;
   int n;

   initial begin
      vecs[0] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_level: 3'd1, exp_ferr: 1'b0};
      vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_level: 3'd1, exp_ferr: 1'b0};
      vecs[2] = '{data: 8'h55, stop: 1'b0, exp_valid: 1'b0, exp_level: 3'd0, exp_ferr: 1'b1};
      vecs[3] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_level: 3'd1, exp_ferr: 1'b0};
      vecs[4] = '{data: 8'h3C, stop: 1'b1, exp_valid: 1'b1, exp_level: 3'd1, exp_ferr: 1'b0};
      vecs[5] = '{data: 8'h6E, stop: 1'b1, exp_valid: 1'b1, exp_level: 3'd1, exp_ferr: 1'b0};

      // Reset
      reset   = 1'b1;
      rx      = 1'b1;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      repeat (3) tick();
      check_status("reset_held", 1'b0, 3'd0, 1'b0, 1'b0);
      reset = 1'b0;
      repeat (3) tick();
      check_status("reset_rel", 1'b0, 3'd0, 1'b0, 1'b0);
      tick();

      // Single byte with timing. The pin falls in cycle 0; the edge is seen
      // in cycle 2 and FSM leaves IDLE on the next edge. rx_valid appears 76
      // edges later, i.e. in cycle 79, the 80th falling clock edge counted.
      first_valid = -1;
      fork
         send_frame(8'hA5, 1'b1, 1'b1);
         begin
            n = 0;
            while (first_valid < 0 && n < 200) begin
               @(negedge clk);
               n++;
               if (rx_valid === 1'b1) first_valid = n;
            end
         end
      join
      check("a5_latency", first_valid, 32'd80);
      check_status("a5_held", 1'b1, 3'd1, 1'b0, 1'b0);
      tick();
      pop_check("a5_pop");
      check_status("a5_after_pop", 1'b0, 3'd0, 1'b0, 1'b0);
      tick();

      // Table-driven frames
      foreach (vecs[k]) begin
         send_frame(vecs[k].data, vecs[k].stop, vecs[k].exp_valid);
         repeat (2) tick();
         check_status($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_level,
                      vecs[k].exp_ferr, 1'b0);
         tick();
         if (vecs[k].exp_valid) pop_check($sformatf("vec%0d_pop", k));
         if (vecs[k].exp_ferr) begin
            pulse_clr();
            check_status($sformatf("vec%0d_clr", k), 1'b0, 3'd0, 1'b0, 1'b0);
            tick();
         end
         // Pop on empty must do nothing.
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
         check_status($sformatf("vec%0d_empty", k), 1'b0, 3'd0, 1'b0, 1'b0);
         tick();
      end

      // Glitch: two cycles low is rejected at the start sample.
      rx = 1'b0;
      repeat (2) tick();
      rx = 1'b1;
      repeat (12) tick();
      check_status("glitch", 1'b0, 3'd0, 1'b0, 1'b0);
      tick();
      send_frame(8'h3C, 1'b1, 1'b1);
      repeat (2) tick();
      check_status("post_glitch", 1'b1, 3'd1, 1'b0, 1'b0);
      tick();
      pop_check("post_glitch_pop");

      // Bad stop bit with clr_err held across the stop sample: set wins.
      fork
         send_frame(8'h55, 1'b0, 1'b0);
         begin
            repeat (76) tick();
            clr_err = 1'b1;
            repeat (3) tick();
            clr_err = 1'b0;
         end
      join
      check_status("set_wins", 1'b0, 3'd0, 1'b1, 1'b0);
      tick();
      pulse_clr();
      check_status("set_wins_clr", 1'b0, 3'd0, 1'b0, 1'b0);
      tick();

      // Overrun: five back-to-back bytes, only four fit.
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, i <= D);
      repeat (2) tick();
      check_status("overrun", 1'b1, 3'd4, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < D; i++) pop_check($sformatf("overrun_pop%0d", i));
      check_status("overrun_drained", 1'b0, 3'd0, 1'b0, 1'b1);
      tick();
      pulse_clr();
      check_status("overrun_clr", 1'b0, 3'd0, 1'b0, 1'b0);
      tick();

      // Full FIFO plus a pop in the push cycle (cycle 78 of the 5th frame).
      for (int i = 0; i < D; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1);
      check_status("full", 1'b1, 3'd4, 1'b0, 1'b0);
      tick();
      fork
         send_frame(8'h14, 1'b1, 1'b1);
         begin
            repeat (78) tick();
            pop_check("full_pop_push");
         end
      join
      repeat (2) tick();
      check_status("full_pop_push_after", 1'b1, 3'd4, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < D; i++) pop_check($sformatf("full_drain%0d", i));
      check_status("full_drained", 1'b0, 3'd0, 1'b0, 1'b0);
      tick();

      // Reset mid-frame with two bytes held and a sticky error.
      send_frame(8'hAA, 1'b1, 1'b1);
      send_frame(8'hBB, 1'b1, 1'b1);
      send_frame(8'h55, 1'b0, 1'b0);
      repeat (2) tick();
      check_status("pre_reset", 1'b1, 3'd2, 1'b1, 1'b0);
      tick();
      rx = 1'b0;
      repeat (C) tick();
      for (int i = 0; i < 3; i++) begin
         rx = i[0];
         repeat (C) tick();
      end
      rx = 1'b1;
      repeat (C / 2) tick();
      reset = 1'b1;
      exp_q.delete();
      check_status("mid_reset", 1'b0, 3'd0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      repeat (20) tick();
      check_status("post_reset_idle", 1'b0, 3'd0, 1'b0, 1'b0);
      tick();
      send_frame(8'hC3, 1'b1, 1'b1);
      repeat (2) tick();
      check_status("post_reset_c3", 1'b1, 3'd1, 1'b0, 1'b0);
      tick();
      pop_check("post_reset_c3_pop");
      check_status("final", 1'b0, 3'd0, 1'b0, 1'b0);

      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
